reg_load_sequencer: RTL and testbench
=====================================

REG_LOAD_SEQUENCER -- requirements
Module: reg_load_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Ports SHALL be as follows:
- Clock  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high reset.
- CmdValid  in  1  command offered.
- CmdOp  in  3  op: 000 INC, 001 DEC, 010 CLR, 011 LOAD8Z, 100 LOAD8S, 101 LOAD16, 110/111 reserved.
- CmdReady  out  1  command accepted when CmdValid&CmdReady.
- ByteValid  in  1  data byte offered.
- ByteIn  in  8  data byte.
- ByteReady  out  1  byte accepted when ByteValid&ByteReady.
- E  out  1  enable to target 16-bit register.
- FunSel  out  3  function select to target register.
- I  out  16  data to target register.
- Done  out  1  one-cycle pulse, command complete.
- Err  out  1  one-cycle pulse, reserved op rejected.

Function
REQ-003 The states SHALL be IDLE, FETCH_LO, ISSUE_LO, FETCH_HI, ISSUE_HI and ISSUE.
REQ-004 CmdReady SHALL be 1 only in IDLE, and ByteReady SHALL be 1 only in FETCH_LO or FETCH_HI.
REQ-005 On IDLE command acceptance, the next state SHALL be:
- INC, DEC or CLR: ISSUE.
- LOAD8Z, LOAD8S or LOAD16: FETCH_LO.
- Reserved op: IDLE, with Err=1 in the following cycle and no E.
REQ-006 On byte acceptance in FETCH_LO, the byte SHALL be latched; the next state SHALL be ISSUE_LO for LOAD16 and ISSUE otherwise.
REQ-007 ISSUE_LO SHALL drive E=1, FunSel=101 and I[7:0]=the low byte for one cycle, then go to FETCH_HI.
REQ-008 On byte acceptance in FETCH_HI, the byte SHALL be latched and the next state SHALL be ISSUE_HI.
REQ-009 ISSUE_HI SHALL drive E=1, FunSel=110 and I[7:0]=the high byte for one cycle, with Done=1, then go to IDLE.
REQ-010 ISSUE SHALL drive E=1 for one cycle with Done=1, then go to IDLE, with FunSel as follows:
- INC 001, DEC 000, CLR 011: I don't-care, driven 0.
- LOAD8Z 100 or LOAD8S 111: I[7:0]=latched byte.
REQ-011 E SHALL be 0 in IDLE, FETCH_LO and FETCH_HI; in those states FunSel SHALL be 010 and I SHALL hold its last value.
REQ-012 I[15:8] SHALL always be 0.
REQ-013 ByteValid outside the FETCH states SHALL be ignored, and the stream SHALL not be consumed.
REQ-014 A FETCH state SHALL wait indefinitely for ByteValid; no timeout.
REQ-015 Latency from command acceptance to Done SHALL be:
- INC, DEC, CLR: 1 cycle.
- LOAD8Z, LOAD8S: 2 cycles, zero byte stalls.
- LOAD16: 4 cycles, zero byte stalls.
REQ-016 Back-to-back commands SHALL be possible; IDLE SHALL accept a new command in the cycle after Done.

Reset
REQ-017 Reset SHALL force the following on the next rising edge, overriding any transfer in progress:
- State IDLE.
- E=0, FunSel=010, I=0.
- Done=0, Err=0.
- Latched bytes 0.
REQ-018 A LOAD16 aborted by Reset between ISSUE_LO and ISSUE_HI SHALL leave the target half-written, and the block SHALL NOT repair it.

Configuration
REQ-019 With macro REG_LOAD_SEQUENCER_SHADOW_EN defined, the block SHALL add outputs Shadow[15:0] and ShadowValid.
REQ-020 In that case, Shadow SHALL apply the same FunSel/I function as the target on every E=1 cycle, so Shadow equals the target Q after each edge.
REQ-021 In that case, ShadowValid SHALL be set by the first completed CLR, LOAD8Z, LOAD8S or LOAD16, and cleared by Reset, which also sets Shadow to 0.
REQ-022 Without the macro, the block SHALL NOT have Shadow or ShadowValid ports or the associated logic.

Structure
REQ-023 Package reg_seq_pkg SHALL hold:
- Op-code constants.
- FunSel constants (DEC 000, INC 001, LOAD 010, CLR 011, LDZ 100, WLO 101, WHI 110, LDS 111).
- The state enum typedef.
REQ-024 Shadow tracking SHALL be the sub-module reg_shadow, instantiated only under REG_LOAD_SEQUENCER_SHADOW_EN.

Verification
REQ-025 The bench SHALL cover the following scenarios:
- LOAD16, bytes 0x34 then 0x12, no stalls -> E cycles FunSel=101 I=0x0034, then FunSel=110 I=0x0012; Done 4 cycles after accept; model register=0x1234.
- LOAD8S byte 0x80, then LOAD8Z byte 0x80 -> FunSel=111 then 100; model 0xFF80 then 0x0080.
- CLR, then DEC -> model 0x0000 then 0xFFFF (wrap); INC -> 0x0000; each Done 1 cycle after accept.
- LOAD16 with ByteValid held low 5 cycles in FETCH_HI -> E stays 0, ByteReady stays 1, Done 9 cycles after accept.
- CmdOp=110 -> Err pulse, no E, CmdReady back in the next cycle.
- Reset asserted in FETCH_HI -> IDLE, E=0, no Done; with the SHADOW_EN macro defined, Shadow=0 and ShadowValid=0.

Source files
------------

// File: rtl/reg_seq_pkg.sv
//------------------------------------------------------------------------------
// reg_seq_pkg
//
// Shared definitions for the register load sequencer:
//   - command op-codes carried on CmdOp
//   - function-select codes driven on FunSel toward the 16-bit target register
//   - FSM state enum and the output-byte select enum
//   - small helpers for op classification and for the target register function
//     (the helper is used by the optional shadow copy of the target)
//------------------------------------------------------------------------------
package reg_seq_pkg;

   // Command op-codes
   localparam logic [2:0] OP_INC    = 3'b000;
   localparam logic [2:0] OP_DEC    = 3'b001;
   localparam logic [2:0] OP_CLR    = 3'b010;
   localparam logic [2:0] OP_LOAD8Z = 3'b011;
   localparam logic [2:0] OP_LOAD8S = 3'b100;
   localparam logic [2:0] OP_LOAD16 = 3'b101;

   // Target register function selects
   localparam logic [2:0] FS_DEC  = 3'b000;
   localparam logic [2:0] FS_INC  = 3'b001;
   localparam logic [2:0] FS_LOAD = 3'b010;
   localparam logic [2:0] FS_CLR  = 3'b011;
   localparam logic [2:0] FS_LDZ  = 3'b100;
   localparam logic [2:0] FS_WLO  = 3'b101;
   localparam logic [2:0] FS_WHI  = 3'b110;
   localparam logic [2:0] FS_LDS  = 3'b111;

   typedef enum logic [2:0] {
      IDLE,
      FETCH_LO,
      ISSUE_LO,
      FETCH_HI,
      ISSUE_HI,
      ISSUE
   } state_t;

   // Which latched byte feeds I[7:0]
   typedef enum logic [1:0] {
      SEL_ZERO,
      SEL_LO,
      SEL_HI
   } isel_t;

   function automatic logic op_is_reserved(input logic [2:0] op);
      return (op == 3'b110) || (op == 3'b111);
   endfunction

   function automatic logic op_needs_byte(input logic [2:0] op);
      return (op == OP_LOAD8Z) || (op == OP_LOAD8S) || (op == OP_LOAD16);
   endfunction

   // FunSel for the byte-less ops (INC / DEC / CLR)
   function automatic logic [2:0] simple_funsel(input logic [2:0] op);
      logic [2:0] fs;
      case (op)
         OP_INC:  fs = FS_INC;
         OP_DEC:  fs = FS_DEC;
         default: fs = FS_CLR;
      endcase
      return fs;
   endfunction

   // Next value of the target register for one enabled cycle
   function automatic logic [15:0] apply_funsel(input logic [15:0] q,
                                                input logic [2:0]  fs,
                                                input logic [15:0] d);
      logic [15:0] n;
      case (fs)
         FS_DEC:  n = q - 16'd1;
         FS_INC:  n = q + 16'd1;
         FS_LOAD: n = d;
         FS_CLR:  n = 16'h0000;
         FS_LDZ:  n = {8'h00, d[7:0]};
         FS_WLO:  n = {q[15:8], d[7:0]};
         FS_WHI:  n = {d[7:0], q[7:0]};
         default: n = {{8{d[7]}}, d[7:0]};
      endcase
      return n;
   endfunction

endpackage

// File: rtl/reg_shadow.sv
//------------------------------------------------------------------------------
// reg_shadow
//
// Local copy of the 16-bit target register. It applies the same FunSel/I
// function the target sees on every E=1 cycle, so Shadow matches the target
// after each clock edge. ShadowValid rises once the copy has been fully
// defined by a completed CLR, LOAD8Z, LOAD8S or LOAD16 (INC/DEC only modify
// an unknown value, so they cannot validate it).
//
// Ports:
//   Clock        in   rising-edge clock
//   Reset        in   synchronous active-high reset (clears Shadow/ShadowValid)
//   E            in   target enable from the sequencer
//   FunSel[2:0]  in   target function select
//   I[15:0]      in   target data
//   Done         in   command-complete pulse from the sequencer
//   Shadow[15:0] out  mirrored target value
//   ShadowValid  out  Shadow holds a fully defined value
//------------------------------------------------------------------------------
module reg_shadow
   import reg_seq_pkg::*;
(
   input  logic        Clock,
   input  logic        Reset,
   input  logic        E,
   input  logic [2:0]  FunSel,
   input  logic [15:0] I,
   input  logic        Done,
   output logic [15:0] Shadow,
   output logic        ShadowValid
);

   logic defines_value;

   // WHI only carries Done as the last write of a LOAD16
   assign defines_value = (FunSel == FS_CLR) || (FunSel == FS_LDZ) ||
                          (FunSel == FS_LDS) || (FunSel == FS_WHI);

   always_ff @(posedge Clock) begin
      if (Reset) begin
         Shadow      <= 16'h0000;
         ShadowValid <= 1'b0;
      end else if (E) begin
         Shadow <= apply_funsel(Shadow, FunSel, I);
         if (Done && defines_value)
            ShadowValid <= 1'b1;
      end
   end

endmodule

// File: rtl/reg_load_sequencer.sv
//------------------------------------------------------------------------------
// reg_load_sequencer
//
// Turns a command stream plus a byte stream into enable/function/data cycles
// for a 16-bit target register with an 8-bit data path. Byte loads take one
// (LOAD8Z/LOAD8S) or two (LOAD16, low byte first) bytes; LOAD16 writes the
// low half then the high half in two separate enabled cycles.
//
// Optional feature: define REG_LOAD_SEQUENCER_SHADOW_EN to add a shadow copy
// of the target register (Shadow, ShadowValid ports and the reg_shadow
// instance). The default build has neither.
//
// Ports:
//   Clock         in   rising-edge clock
//   Reset         in   synchronous active-high reset
//   CmdValid      in   command offered
//   CmdOp[2:0]    in   op (INC, DEC, CLR, LOAD8Z, LOAD8S, LOAD16; 110/111 reserved)
//   CmdReady      out  command accepted when CmdValid & CmdReady (IDLE only)
//   ByteValid     in   data byte offered
//   ByteIn[7:0]   in   data byte
//   ByteReady     out  byte accepted when ByteValid & ByteReady (FETCH states)
//   E             out  target enable
//   FunSel[2:0]   out  target function select (LOAD code while idle/fetching)
//   I[15:0]       out  target data, upper byte always zero
//   Done          out  one-cycle pulse on the final enabled cycle of a command
//   Err           out  one-cycle pulse after a reserved op is rejected
//   Shadow[15:0]  out  (SHADOW_EN only) mirrored target value
//   ShadowValid   out  (SHADOW_EN only) Shadow fully defined
//------------------------------------------------------------------------------
module reg_load_sequencer
   import reg_seq_pkg::*;
(
   input  logic        Clock,
   input  logic        Reset,
   input  logic        CmdValid,
   input  logic [2:0]  CmdOp,
   output logic        CmdReady,
   input  logic        ByteValid,
   input  logic [7:0]  ByteIn,
   output logic        ByteReady,
   output logic        E,
   output logic [2:0]  FunSel,
   output logic [15:0] I,
   output logic        Done,
   output logic        Err
`ifdef REG_LOAD_SEQUENCER_SHADOW_EN
   ,
   output logic [15:0] Shadow,
   output logic        ShadowValid
`endif
);

   state_t     state;
   logic [2:0] op_q;
   logic [7:0] lo_byte;
   logic [7:0] hi_byte;
   isel_t      i_sel;
   logic [7:0] i_lo;

   assign CmdReady  = (state == IDLE);
   assign ByteReady = (state == FETCH_LO) || (state == FETCH_HI);

   // I is a select over the latched bytes. The select only changes when an
   // enabled cycle is entered, so I holds its last value through IDLE and
   // the FETCH states, and resets to zero with the bytes.
   always_comb begin
      i_lo = 8'h00;
      case (i_sel)
         SEL_LO:  i_lo = lo_byte;
         SEL_HI:  i_lo = hi_byte;
         default: i_lo = 8'h00;
      endcase
   end

   assign I = {8'h00, i_lo};

   // E/FunSel/Done/Err are registered on entry to the state they belong to,
   // so they are valid for exactly the cycle spent in that state.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state   <= IDLE;
         op_q    <= OP_INC;
         lo_byte <= 8'h00;
         hi_byte <= 8'h00;
         i_sel   <= SEL_ZERO;
         E       <= 1'b0;
         FunSel  <= FS_LOAD;
         Done    <= 1'b0;
         Err     <= 1'b0;
      end else begin
         E      <= 1'b0;
         FunSel <= FS_LOAD;
         Done   <= 1'b0;
         Err    <= 1'b0;

         case (state)
            IDLE: begin
               if (CmdValid) begin
                  if (op_is_reserved(CmdOp)) begin
                     Err <= 1'b1;
                  end else if (op_needs_byte(CmdOp)) begin
                     op_q  <= CmdOp;
                     state <= FETCH_LO;
                  end else begin
                     op_q   <= CmdOp;
                     state  <= ISSUE;
                     E      <= 1'b1;
                     Done   <= 1'b1;
                     FunSel <= simple_funsel(CmdOp);
                     i_sel  <= SEL_ZERO;
                  end
               end
            end

            FETCH_LO: begin
               if (ByteValid) begin
                  lo_byte <= ByteIn;
                  i_sel   <= SEL_LO;
                  E       <= 1'b1;
                  if (op_q == OP_LOAD16) begin
                     state  <= ISSUE_LO;
                     FunSel <= FS_WLO;
                  end else begin
                     state  <= ISSUE;
                     Done   <= 1'b1;
                     FunSel <= (op_q == OP_LOAD8S) ? FS_LDS : FS_LDZ;
                  end
               end
            end

            ISSUE_LO: begin
               state <= FETCH_HI;
            end

            FETCH_HI: begin
               if (ByteValid) begin
                  hi_byte <= ByteIn;
                  i_sel   <= SEL_HI;
                  state   <= ISSUE_HI;
                  E       <= 1'b1;
                  Done    <= 1'b1;
                  FunSel  <= FS_WHI;
               end
            end

            ISSUE_HI,
            ISSUE: begin
               state <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef REG_LOAD_SEQUENCER_SHADOW_EN
   reg_shadow u_shadow (
      .Clock       (Clock),
      .Reset       (Reset),
      .E           (E),
      .FunSel      (FunSel),
      .I           (I),
      .Done        (Done),
      .Shadow      (Shadow),
      .ShadowValid (ShadowValid)
   );
`else
   // No shadow copy of the target in this build.
`endif

endmodule

// File: tb/tb_reg_load_sequencer.sv
//------------------------------------------------------------------------------
// tb_reg_load_sequencer
//
// Directed bench for reg_load_sequencer. A behavioural model of the 16-bit
// target register follows E/FunSel/I so that the effect of each command can
// be compared with hand-computed register values. Define
// REG_LOAD_SEQUENCER_SHADOW_EN to also exercise the shadow outputs.
//------------------------------------------------------------------------------
module tb_reg_load_sequencer;

   logic        Clock = 1'b0;
   logic        Reset;
   logic        CmdValid;
   logic [2:0]  CmdOp;
   logic        CmdReady;
   logic        ByteValid;
   logic [7:0]  ByteIn;
   logic        ByteReady;
   logic        E;
   logic [2:0]  FunSel;
   logic [15:0] I;
   logic        Done;
   logic        Err;
`ifdef REG_LOAD_SEQUENCER_SHADOW_EN
   logic [15:0] Shadow;
   logic        ShadowValid;
`endif

   int checks   = 0;
   int failures = 0;

   logic [15:0] model = 16'h0000;

   always #5 Clock = ~Clock;

   reg_load_sequencer dut (
      .Clock     (Clock),
      .Reset     (Reset),
      .CmdValid  (CmdValid),
      .CmdOp     (CmdOp),
      .CmdReady  (CmdReady),
      .ByteValid (ByteValid),
      .ByteIn    (ByteIn),
      .ByteReady (ByteReady),
      .E         (E),
      .FunSel    (FunSel),
      .I         (I),
      .Done      (Done),
      .Err       (Err)
`ifdef REG_LOAD_SEQUENCER_SHADOW_EN
      ,
      .Shadow      (Shadow),
      .ShadowValid (ShadowValid)
`endif
   );

   // Target register: 000 DEC, 001 INC, 010 LOAD, 011 CLR, 100 LDZ,
   // 101 write low, 110 write high, 111 LDS
   always @(posedge Clock) begin
      if (E) begin
         case (FunSel)
            3'b000:  model <= model - 16'd1;
            3'b001:  model <= model + 16'd1;
            3'b010:  model <= I;
            3'b011:  model <= 16'h0000;
            3'b100:  model <= {8'h00, I[7:0]};
            3'b101:  model <= {model[15:8], I[7:0]};
            3'b110:  model <= {I[7:0], model[7:0]};
            default: model <= {{8{I[7]}}, I[7:0]};
         endcase
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge Clock);
      #1;
   endtask

   // Offer one command in the current (IDLE) cycle, feed its bytes, and stop
   // one cycle after Done. lat counts cycles from the accept cycle to Done.
   task automatic issue(input logic [2:0] op, input logic [7:0] b0, input logic [7:0] b1,
                        input int stall, output int lat, output int ne,
                        output logic [2:0] fs0, output logic [15:0] i0,
                        output logic [2:0] fs1, output logic [15:0] i1,
                        output int stall_ok);
      int   nb;
      int   sc;
      logic done_seen;
      logic took;
      nb = 0; sc = 0; ne = 0; lat = 0; stall_ok = 0; done_seen = 1'b0;
      fs0 = 3'b0; i0 = 16'h0; fs1 = 3'b0; i1 = 16'h0;
      check("cmd_ready", {31'b0, CmdReady}, 32'd1);
      CmdValid  = 1'b1;
      CmdOp     = op;
      ByteValid = 1'b0;
      step();
      CmdValid = 1'b0;
      for (int cyc = 1; cyc <= 40 && !done_seen; cyc++) begin
         if (E) begin
            if (ne == 0) begin fs0 = FunSel; i0 = I; end
            else begin fs1 = FunSel; i1 = I; end
            ne++;
         end
         if (Done) begin
            done_seen = 1'b1;
            lat = cyc;
         end else begin
            if (ByteReady) begin
               if (nb == 1 && sc < stall) begin
                  ByteValid = 1'b0;
                  sc++;
                  if (!E) stall_ok++;
               end else begin
                  ByteValid = 1'b1;
                  ByteIn    = (nb == 0) ? b0 : b1;
               end
            end else begin
               ByteValid = 1'b0;
            end
            took = ByteValid & ByteReady;
            step();
            if (took) nb++;
         end
      end
      ByteValid = 1'b0;
      step();
`ifdef REG_LOAD_SEQUENCER_SHADOW_EN
      check("shadow_track", {16'b0, Shadow}, {16'b0, model});
`endif
   endtask

   int          lat, ne, sok;
   logic [2:0]  fs0, fs1;
   logic [15:0] i0, i1;
   int          done_cnt;

   initial begin
      Reset = 1'b1; CmdValid = 1'b0; CmdOp = 3'b000; ByteValid = 1'b0; ByteIn = 8'h00;
      step();
      step();
      check("rst_E",         {31'b0, E},         32'd0);
      check("rst_FunSel",    {29'b0, FunSel},    32'd2);
      check("rst_I",         {16'b0, I},         32'd0);
      check("rst_Done",      {31'b0, Done},      32'd0);
      check("rst_Err",       {31'b0, Err},       32'd0);
      check("rst_CmdReady",  {31'b0, CmdReady},  32'd1);
      check("rst_ByteReady", {31'b0, ByteReady}, 32'd0);
      Reset = 1'b0;
      step();

      // LOAD16 0x34, 0x12, no stalls
      issue(3'b101, 8'h34, 8'h12, 0, lat, ne, fs0, i0, fs1, i1, sok);
      check("l16_lat",   lat,            32'd4);
      check("l16_ne",    ne,             32'd2);
      check("l16_fs_lo", {29'b0, fs0},   32'h5);
      check("l16_i_lo",  {16'b0, i0},    32'h0034);
      check("l16_fs_hi", {29'b0, fs1},   32'h6);
      check("l16_i_hi",  {16'b0, i1},    32'h0012);
      check("l16_model", {16'b0, model}, 32'h1234);
`ifdef REG_LOAD_SEQUENCER_SHADOW_EN
      check("l16_svalid", {31'b0, ShadowValid}, 32'd1);
`endif

      // Bytes offered in IDLE are not consumed
      ByteValid = 1'b1; ByteIn = 8'hEE;
      for (int k = 0; k < 3; k++) begin
         check("idle_byte_ready", {31'b0, ByteReady}, 32'd0);
         step();
      end
      ByteValid = 1'b0;

      // LOAD8S 0x80 then LOAD8Z 0x80
      issue(3'b100, 8'h80, 8'h00, 0, lat, ne, fs0, i0, fs1, i1, sok);
      check("l8s_lat",   lat,            32'd2);
      check("l8s_fs",    {29'b0, fs0},   32'h7);
      check("l8s_i",     {16'b0, i0},    32'h0080);
      check("l8s_model", {16'b0, model}, 32'hFF80);
      issue(3'b011, 8'h80, 8'h00, 0, lat, ne, fs0, i0, fs1, i1, sok);
      check("l8z_lat",   lat,            32'd2);
      check("l8z_fs",    {29'b0, fs0},   32'h4);
      check("l8z_model", {16'b0, model}, 32'h0080);

      // CLR, DEC (wrap), INC
      issue(3'b010, 8'h00, 8'h00, 0, lat, ne, fs0, i0, fs1, i1, sok);
      check("clr_lat",   lat,            32'd1);
      check("clr_fs",    {29'b0, fs0},   32'h3);
      check("clr_i",     {16'b0, i0},    32'h0000);
      check("clr_model", {16'b0, model}, 32'h0000);
      issue(3'b001, 8'h00, 8'h00, 0, lat, ne, fs0, i0, fs1, i1, sok);
      check("dec_lat",   lat,            32'd1);
      check("dec_fs",    {29'b0, fs0},   32'h0);
      check("dec_model", {16'b0, model}, 32'hFFFF);
      issue(3'b000, 8'h00, 8'h00, 0, lat, ne, fs0, i0, fs1, i1, sok);
      check("inc_lat",   lat,            32'd1);
      check("inc_fs",    {29'b0, fs0},   32'h1);
      check("inc_model", {16'b0, model}, 32'h0000);

      // LOAD16 with 5 stall cycles in FETCH_HI
      issue(3'b101, 8'hCD, 8'hAB, 5, lat, ne, fs0, i0, fs1, i1, sok);
      check("stall_lat",   lat,            32'd9);
      check("stall_cyc",   sok,            32'd5);
      check("stall_ne",    ne,             32'd2);
      check("stall_model", {16'b0, model}, 32'hABCD);

      // Reserved op
      CmdValid = 1'b1; CmdOp = 3'b110;
      step();
      CmdValid = 1'b0;
      check("rsv_err",      {31'b0, Err},      32'd1);
      check("rsv_E",        {31'b0, E},        32'd0);
      check("rsv_done",     {31'b0, Done},     32'd0);
      check("rsv_cmdready", {31'b0, CmdReady}, 32'd1);
      step();
      check("rsv_err_pulse", {31'b0, Err}, 32'd0);
      check("rsv_E2",        {31'b0, E},   32'd0);

      // LOAD16 aborted by Reset in FETCH_HI: low half stays written
      CmdValid = 1'b1; CmdOp = 3'b101;
      step();
      CmdValid = 1'b0;
      ByteValid = 1'b1; ByteIn = 8'h55;
      step();
      ByteValid = 1'b0;
      check("abort_wlo_E",  {31'b0, E},      32'd1);
      check("abort_wlo_fs", {29'b0, FunSel}, 32'h5);
      step();
      check("abort_fetch_hi", {31'b0, ByteReady}, 32'd1);
      Reset = 1'b1;
      step();
      Reset = 1'b0;
      check("abort_idle",   {31'b0, CmdReady},  32'd1);
      check("abort_bready", {31'b0, ByteReady}, 32'd0);
      check("abort_E",      {31'b0, E},         32'd0);
      check("abort_done",   {31'b0, Done},      32'd0);
      check("abort_fs",     {29'b0, FunSel},    32'h2);
      check("abort_I",      {16'b0, I},         32'h0000);
      check("abort_model",  {16'b0, model},     32'hAB55);
`ifdef REG_LOAD_SEQUENCER_SHADOW_EN
      check("abort_shadow", {16'b0, Shadow},      32'h0000);
      check("abort_svalid", {31'b0, ShadowValid}, 32'd0);
`endif
      done_cnt = 0;
      for (int k = 0; k < 4; k++) begin
         if (Done || E) done_cnt++;
         step();
      end
      check("abort_no_done", done_cnt, 32'd0);

      // Back to normal after the abort
      issue(3'b011, 8'h7F, 8'h00, 0, lat, ne, fs0, i0, fs1, i1, sok);
      check("post_lat",   lat,            32'd2);
      check("post_model", {16'b0, model}, 32'h007F);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
